// File: rtl/imm_pkg.sv
// Shared types and the immediate construction function for the decode-stage immediate extender.
// build_imm returns a 32-bit immediate that is already sign-correct at bit 31; callers widen it by sign extension.
package imm_pkg;

    localparam int unsigned IMM_BASE_W = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100,
        IMM_Z = 3'b101
    } imm_src_e;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_FULL
    } buf_state_e;

    typedef struct packed {
        logic                  illegal;
        logic [IMM_BASE_W-1:0] imm;
    } imm_res_t;

    // Zimm has bit 31 clear, so sign-extending every result to XLEN is also correct for it.
    function automatic imm_res_t build_imm(input logic [31:7] instr, input logic [2:0] src);
        imm_res_t r;
        r.illegal = 1'b0;
        r.imm     = '0;
        case (src)
            IMM_I:   r.imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   r.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   r.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   r.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   r.imm = {instr[31:12], 12'b0};
            IMM_Z:   r.imm = {27'b0, instr[19:15]};
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_build.sv
// Combinational immediate decode: instruction bits and type select to XLEN-wide immediate plus illegal flag.
module imm_build
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      immSrc,
    output logic [XLEN-1:0] ImmExt,
    output logic            illegal
);

    imm_res_t res;

    always_comb begin
        res     = build_imm(instr, immSrc);
        ImmExt  = XLEN'($signed(res.imm));
        illegal = res.illegal;
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with a two-entry skid buffer on a valid/ready output interface.
// in_ready depends only on registered state; flush empties the buffer and drops any offered beat.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:7]     instr,
    input  logic [2:0]      immSrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ImmExt,
    output logic            illegal
);

    buf_state_e      state, state_nxt;
    logic [XLEN-1:0] new_imm, main_imm, skid_imm;
    logic            new_ill, main_ill, skid_ill;
    logic            acc, pop;

    imm_build #(.XLEN(XLEN)) u_build (
        .instr   (instr),
        .immSrc  (immSrc),
        .ImmExt  (new_imm),
        .illegal (new_ill)
    );

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= BUF_EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (acc) state_nxt = BUF_ONE;
                BUF_ONE: begin
                    if (acc && !pop)      state_nxt = BUF_FULL;
                    else if (!acc && pop) state_nxt = BUF_EMPTY;
                end
                BUF_FULL:  if (pop) state_nxt = BUF_ONE;
                default:   state_nxt = BUF_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state != BUF_FULL);
        out_valid = (state != BUF_EMPTY);
    end

    // Main entry drives the outputs, so it is reset; the skid entry is only read while valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_imm <= '0;
            main_ill <= 1'b0;
        end else if (!flush) begin
            if (state == BUF_FULL && pop) begin
                main_imm <= skid_imm;
                main_ill <= skid_ill;
            end else if (acc && (state == BUF_EMPTY || pop)) begin
                main_imm <= new_imm;
                main_ill <= new_ill;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && acc && state == BUF_ONE && !pop) begin
            skid_imm <= new_imm;
            skid_ill <= new_ill;
        end
    end

    assign ImmExt  = main_imm;
    assign illegal = main_ill;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe at XLEN=32 and XLEN=64 driven with identical stimulus.
module tb_imm_ext_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, out_ready;
    logic [31:7] instr;
    logic [2:0]  immsrc;
    logic        in_ready32, out_valid32, illegal32;
    logic        in_ready64, out_valid64, illegal64;
    logic [31:0] ImmExt32;
    logic [63:0] ImmExt64;

    logic [63:0] exp_imm;
    logic        exp_ill;
    exp_t        q32[$];
    exp_t        q64[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .immSrc(immsrc), .out_valid(out_valid32), .out_ready(out_ready),
        .ImmExt(ImmExt32), .illegal(illegal32)
    );

    imm_ext_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immSrc(immsrc), .out_valid(out_valid64), .out_ready(out_ready),
        .ImmExt(ImmExt64), .illegal(illegal64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference immediate built by shifting fields into place over a sign mask.
    function automatic logic [64:0] model(input logic [31:0] w, input logic [2:0] s);
        logic [63:0] s31, r;
        logic        ill;
        s31 = w[31] ? '1 : '0;
        ill = 1'b0;
        case (s)
            3'd0: r = (s31 << 11) | 64'(w[30:20]);
            3'd1: r = (s31 << 11) | (64'(w[30:25]) << 5) | 64'(w[11:7]);
            3'd2: r = (s31 << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1);
            3'd3: r = (s31 << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11) | (64'(w[30:21]) << 1);
            3'd4: r = (s31 << 31) | (64'(w[30:12]) << 12);
            3'd5: r = 64'(w[19:15]);
            default: begin r = '0; ill = 1'b1; end
        endcase
        return {ill, r};
    endfunction

    // Scoreboard: push on accept, pop on output transfer, clear on flush.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (out_valid32 && out_ready) begin
                    if (q32.size() == 0) check("sb32_unexpected", 64'd1, 64'd0);
                    else begin
                        e = q32.pop_front();
                        check("sb32_imm", 64'(ImmExt32), {32'd0, e.imm[31:0]});
                        check("sb32_ill", 64'(illegal32), 64'(e.ill));
                    end
                end
                if (out_valid64 && out_ready) begin
                    if (q64.size() == 0) check("sb64_unexpected", 64'd1, 64'd0);
                    else begin
                        e = q64.pop_front();
                        check("sb64_imm", ImmExt64, e.imm);
                        check("sb64_ill", 64'(illegal64), 64'(e.ill));
                    end
                end
                if (in_valid && in_ready32) q32.push_back('{imm: exp_imm, ill: exp_ill});
                if (in_valid && in_ready64) q64.push_back('{imm: exp_imm, ill: exp_ill});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] w, input logic [2:0] s);
        logic [64:0] m;
        m        = model(w, s);
        instr    = w[31:7];
        immsrc   = s;
        exp_imm  = m[63:0];
        exp_ill  = m[64];
        in_valid = 1'b1;
    endtask

    task automatic one_beat(input string tag, input logic [31:0] w, input logic [2:0] s,
                            input logic [63:0] e, input logic eill);
        out_ready = 1'b1;
        drive(w, s);
        tick();
        in_valid = 1'b0;
        check({tag, "_vld"}, 64'({out_valid32, out_valid64}), 64'd3);
        check({tag, "_32"}, 64'(ImmExt32), {32'd0, e[31:0]});
        check({tag, "_64"}, ImmExt64, e);
        check({tag, "_ill"}, 64'({illegal32, illegal64}), eill ? 64'd3 : 64'd0);
        tick();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vld"}, 64'({out_valid32, out_valid64}), 64'd0);
        check({tag, "_rdy"}, 64'({in_ready32, in_ready64}), 64'd3);
        check({tag, "_imm"}, ImmExt64 | 64'(ImmExt32), 64'd0);
        check({tag, "_ill"}, 64'({illegal32, illegal64}), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        immsrc    = '0;
        exp_imm   = '0;
        exp_ill   = 1'b0;
        tick();
        check_idle("reset");
        tick();
        reset_n = 1'b1;
        tick();

        one_beat("imm_i", 32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        one_beat("imm_s", 32'hFE20AE23, 3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        one_beat("imm_b", 32'hFE000CE3, 3'b010, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        one_beat("imm_u", 32'h123450B7, 3'b100, 64'h0000_0000_1234_5000, 1'b0);
        one_beat("imm_u_neg", 32'h800000B7, 3'b100, 64'hFFFF_FFFF_8000_0000, 1'b0);
        one_beat("imm_z", 32'h000F8073, 3'b101, 64'h0000_0000_0000_001F, 1'b0);
        one_beat("imm_j", 32'h8000006F, 3'b011, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
        one_beat("illegal", 32'hFFFFFFFF, 3'b110, 64'd0, 1'b1);

        // Backpressure: two beats fill the buffer, the third is held off.
        out_ready = 1'b0;
        drive(32'hFFF00093, 3'b000);
        tick();
        drive(32'hFE20AE23, 3'b001);
        tick();
        drive(32'hFE000CE3, 3'b010);
        tick();
        check("bp_full_rdy", 64'({in_ready32, in_ready64}), 64'd0);
        check("bp_hold_imm", 64'(ImmExt32), 64'hFFFF_FFFF);
        tick();
        check("bp_hold_imm2", 64'(ImmExt32), 64'hFFFF_FFFF);
        check("bp_hold_vld", 64'(out_valid32), 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp_second", 64'(ImmExt32), 64'hFFFF_FFFC);
        check("bp_rdy_again", 64'(in_ready32), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_third", 64'(ImmExt32), 64'hFFFF_FFF8);
        tick();
        check("bp_drained", 64'(out_valid32), 64'd0);

        // Flush while full with a beat on offer.
        out_ready = 1'b0;
        drive(32'h00500093, 3'b000);
        tick();
        drive(32'h00600093, 3'b000);
        tick();
        drive(32'h00700093, 3'b000);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_vld", 64'({out_valid32, out_valid64}), 64'd0);
        check("flush_rdy", 64'({in_ready32, in_ready64}), 64'd3);
        out_ready = 1'b1;
        repeat (3) tick();

        // Randomised traffic with source-held beats and occasional flush.
        for (int unsigned i = 0; i < 400; i++) begin
            logic moved;
            moved = !in_valid || in_ready32 || flush;
            flush = 1'b0;
            if (moved) begin
                drive($urandom, 3'($urandom_range(0, 7)));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain64", 64'(q64.size()), 64'd0);

        // Asynchronous reset while full.
        out_ready = 1'b0;
        drive(32'hFFF00093, 3'b000);
        tick();
        drive(32'hFE20AE23, 3'b001);
        tick();
        in_valid = 1'b0;
        check("arst_full", 64'(in_ready32), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("arst");
        q32.delete();
        q64.delete();
        tick();
        reset_n = 1'b1;
        tick();
        one_beat("post_rst", 32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Registered, parametrised immediate extender for the pipelined core's decode stage. It takes the instruction's upper bits plus an immediate-type select, builds the sign- or zero-extended immediate at width XLEN, and hands it to execute through a valid/ready interface. A two-entry skid buffer absorbs execute-stage backpressure. Beyond the I/S/B/J types it also produces U-type and CSR zimm immediates, flags illegal selects, and supports synchronous flush on redirect.

## Interface

- XLEN, 32, datapath width; legal values 32 or 64.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all buffered entries (branch/jump redirect)
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  block can accept this cycle
- instr  input  [31:7]  instruction bits 31..7
- immSrc  input  3  immediate type, see encoding
- out_valid  output  1  ImmExt/illegal valid
- out_ready  input  1  execute consumes this cycle
- ImmExt  output  XLEN  extended immediate
- illegal  output  1  immSrc was an unused encoding

## Operation

- immSrc encoding:
  - 000 I: sext(instr[31:20])
  - 001 S: sext({instr[31:25], instr[11:7]})
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - 100 U: sext({instr[31:12], 12'b0})
  - 101 Z: zero-extend instr[19:15]
  - 110/111: ImmExt = 0, illegal = 1
- sext replicates instr[31] up to bit XLEN-1. For XLEN=64, U-type is also sign-extended from bit 31.
- Immediate computation is combinational on the input side. The result and the illegal bit are registered into the buffer.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main entry valid, in_ready=1.
  - FULL: main and skid entries valid, in_ready=0.
- Transitions, where acc = in_valid & in_ready and pop = out_valid & out_ready:
  - EMPTY + acc → ONE.
  - ONE + acc and no pop → FULL; the new beat goes to skid.
  - ONE + acc + pop → ONE; main is replaced by the new beat.
  - ONE + pop and no acc → EMPTY.
  - FULL + pop → ONE; skid moves to main.
- Order is strictly preserved. A beat is never duplicated or dropped except by flush.
- flush has priority over acc and pop. The next state is EMPTY, and a beat offered in the flush cycle is discarded.

## Timing

- Reset values: out_valid=0, ImmExt=0, illegal=0, in_ready=1, state EMPTY. The reset is asynchronous and is applied mid-transfer with no drain.
- Latency: 1 cycle from acc to out_valid when the buffer was EMPTY.
- in_ready is a pure function of registered state (state != FULL). It has no combinational path from out_ready.
- ImmExt and illegal hold stable while out_valid=1 and out_ready=0.
- Throughput is 1 beat/cycle with out_ready held high.
- Data registers do not need reset beyond the outputs above. Skid data may be X while the skid entry is invalid.

## Structure

- Package imm_pkg holds:
  - enum imm_src_e (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z)
  - buffer-state enum
  - a function build_imm(instr, src) parametrised to XLEN via a width argument or a localparam.
- Sub-module imm_build: a combinational decode of instr/immSrc into {illegal, ImmExt}. The top holds the skid buffer and the FSM.

## Test plan

- XLEN=32 single beats with out_ready=1:
  - I instr=0xFFF00093 → 0xFFFFFFFF.
  - S 0xFE20AE23 → 0xFFFFFFFC.
  - B 0xFE000CE3 → 0xFFFFFFF8.
  - U 0x123450B7 → 0x12345000.
  - Each appears 1 cycle after acc.
- XLEN=64:
  - U instr=0x800000B7 → 0xFFFFFFFF80000000.
  - Z with instr[19:15]=5'h1F → 0x000000000000001F.
- Backpressure: hold out_ready=0 and offer 3 beats (I, S, B above).
  - Required: 2 accepted, then in_ready=0.
  - After out_ready=1: outputs 0xFFFFFFFF, 0xFFFFFFFC in order, then the third beat is accepted and drains as 0xFFFFFFF8.
- Illegal: immSrc=3'b110 → illegal=1, ImmExt=0, out_valid=1.
- Flush with FULL buffer and in_valid=1 → next cycle out_valid=0, in_ready=1, and the offered beat never appears.
- Reset: assert reset_n=0 asynchronously while FULL → out_valid=0 and ImmExt=0 immediately, without waiting for a clock edge.
